event_fifo_loader: RTL and testbench

- Far end of the event-router handshake. Accepts each routed 63-bit event on load_event and appends an odd-parity bit to form the full 64-bit packet.
- Writes the packet into the chip-shared event FIFO, then returns a one-cycle fifo_ack so the router can advance.
- Exposes a first-word-fall-through read port to the UART/comms transmitter, plus occupancy flags.

---
 rtl/event_fifo_loader.sv | 99 +++++++++
 tb/tb_event_fifo_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/event_fifo_loader.sv
// Router-side event loader: adds odd parity to each routed event, writes it into a
// FWFT FIFO with a three-state ack handshake, and exposes occupancy flags.
//
// state   | meaning
// IDLE    | waiting for load_event; writes when the FIFO is not full
// ACK     | packet written this cycle, fifo_ack high
// RELEASE | waiting for the router to drop load_event
module event_fifo_loader #(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-2:0]     channel_event_out,
  input  logic                 load_event,
  output logic                 fifo_ack,
  input  logic                 read_fifo,
  output logic [WIDTH-1:0]     fifo_data_out,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 fifo_half,
  output logic [FIFO_BITS:0]   fifo_counter
);

  localparam logic [FIFO_BITS:0] DEPTH_CNT = FIFO_DEPTH[FIFO_BITS:0];
  localparam logic [FIFO_BITS:0] HALF_CNT  = DEPTH_CNT >> 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic                   wr_en;
  logic                   rd_en;
  logic [FIFO_BITS-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_BITS:0]     count_next;
  logic [WIDTH-1:0]       packet;
  logic [WIDTH-1:0]       mem [FIFO_DEPTH];

  assign packet        = {~^channel_event_out, channel_event_out};
  assign rd_en         = read_fifo && !fifo_empty;
  assign fifo_data_out = mem[rd_ptr];

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (load_event && !fifo_full) begin
          wr_en      = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = RELEASE;
      RELEASE: if (!load_event) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = fifo_counter;
    case ({wr_en, rd_en})
      2'b10:   count_next = fifo_counter + 1'b1;
      2'b01:   count_next = fifo_counter - 1'b1;
      default: count_next = fifo_counter;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      fifo_ack     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
      fifo_empty   <= 1'b1;
      fifo_full    <= 1'b0;
      fifo_half    <= 1'b0;
    end else begin
      state        <= state_next;
      fifo_ack     <= wr_en;
      fifo_counter <= count_next;
      fifo_empty   <= (count_next == '0);
      fifo_full    <= (count_next == DEPTH_CNT);
      fifo_half    <= (count_next >= HALF_CNT);
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is never cleared; a write is dropped if reset is asserted on the same edge.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) mem[wr_ptr] <= packet;
  end

endmodule

// File: tb/tb_event_fifo_loader.sv
// Directed bench for event_fifo_loader: scoreboard of expected packets pushed on
// each request and compared against the FWFT head on every pop.
module tb_event_fifo_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [62:0] channel_event_out = '0;
  logic        load_event = 1'b0;
  logic        fifo_ack;
  logic        read_fifo = 1'b0;
  logic [63:0] fifo_data_out;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_half;
  logic [4:0]  fifo_counter;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  event_fifo_loader #(.WIDTH(64), .FIFO_DEPTH(16), .FIFO_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .channel_event_out(channel_event_out),
    .load_event(load_event), .fifo_ack(fifo_ack), .read_fifo(read_fifo),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_half(fifo_half), .fifo_counter(fifo_counter)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pkt(input logic [62:0] ev);
    return {~^ev, ev};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input int cnt);
    chk({tag, "_count"}, 64'(fifo_counter), 64'(cnt));
    chk({tag, "_empty"}, 64'(fifo_empty), 64'(cnt == 0));
    chk({tag, "_full"},  64'(fifo_full),  64'(cnt == 16));
    chk({tag, "_half"},  64'(fifo_half),  64'(cnt >= 8));
  endtask

  // Compare the FWFT head with the scoreboard, then pop for one edge.
  task automatic pop(input string tag);
    logic [63:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=pop expected=scoreboard_entry", tag);
    end else begin
      exp = sb.pop_front();
      chk(tag, fifo_data_out, exp);
    end
    read_fifo = 1'b1;
    tick();
    read_fifo = 1'b0;
  endtask

  // Full handshake; leaves the FSM in IDLE with load_event low.
  task automatic send(input logic [62:0] ev, input bit hold_extra);
    int n;
    channel_event_out = ev;
    load_event = 1'b1;
    sb.push_back(pkt(ev));
    n = 0;
    do begin
      tick();
      n++;
    end while (!fifo_ack && n < 20);
    chk("ack_seen", 64'(fifo_ack), 64'd1);
    if (hold_extra) begin
      tick();
      chk("ack_one_cycle", 64'(fifo_ack), 64'd0);
      tick();
      load_event = 1'b0;
      tick();
    end else begin
      load_event = 1'b0;
      tick();
      chk("ack_one_cycle", 64'(fifo_ack), 64'd0);
      tick();
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ack", 64'(fifo_ack), 64'd0);
    chk_flags("rst", 0);
    reset_n = 1'b1;
    tick();

    // Zero event carries parity 1 in the top bit
    send(63'h0, 1'b0);
    chk("zero_pkt", fifo_data_out, 64'h8000_0000_0000_0000);
    chk_flags("one", 1);
    pop("pop_zero");
    chk_flags("pop_zero", 0);

    send(63'h1, 1'b0);
    chk("one_bit_pkt", fifo_data_out, 64'h0000_0000_0000_0001);
    pop("pop_one_bit");
    chk_flags("after_one_bit", 0);

    // Trailing request must not double-write
    send(63'h5, 1'b1);
    chk_flags("trailing", 1);
    send(63'h6, 1'b0);
    chk_flags("second", 2);
    pop("pop_tr0");
    pop("pop_tr1");
    chk_flags("tr_drained", 0);

    for (int i = 0; i < 16; i++) begin
      send(63'(i), 1'b0);
      if (i == 6) chk("half_at7", 64'(fifo_half), 64'd0);
      if (i == 7) chk("half_at8", 64'(fifo_half), 64'd1);
    end
    chk_flags("filled", 16);

    // 17th request stalls until a pop frees a slot
    channel_event_out = 63'd16;
    load_event = 1'b1;
    sb.push_back(pkt(63'd16));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_no_ack", 64'(fifo_ack), 64'd0);
    end
    pop("pop_full_head");
    chk("full_pop_ack", 64'(fifo_ack), 64'd0);
    chk("full_pop_count", 64'(fifo_counter), 64'd15);
    tick();
    chk("late_ack", 64'(fifo_ack), 64'd1);
    chk_flags("refilled", 16);
    load_event = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 16; i++) pop("drain");
    chk_flags("drained", 0);

    // Simultaneous write and pop at count 5
    for (int i = 0; i < 5; i++) send(63'h100 + 63'(i), 1'b0);
    chk_flags("five", 5);
    channel_event_out = 63'h7fff_0000_1234_5678;
    load_event = 1'b1;
    sb.push_back(pkt(63'h7fff_0000_1234_5678));
    pop("pop_simul");
    chk("simul_ack", 64'(fifo_ack), 64'd1);
    chk_flags("simul", 5);
    load_event = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) pop("drain_simul");
    chk_flags("simul_drained", 0);
    read_fifo = 1'b1;
    tick();
    read_fifo = 1'b0;
    chk_flags("read_empty", 0);

    // Reset while in ACK
    channel_event_out = 63'h2a;
    load_event = 1'b1;
    tick();
    chk("pre_rst_ack", 64'(fifo_ack), 64'd1);
    reset_n = 1'b0;
    tick();
    chk("rst_ack_drop", 64'(fifo_ack), 64'd0);
    chk_flags("rst_mid", 0);
    sb.delete();
    reset_n = 1'b1;
    channel_event_out = 63'h3c;
    sb.push_back(pkt(63'h3c));
    tick();
    chk("idle_after_rst", 64'(fifo_ack), 64'd1);
    chk_flags("post_rst", 1);
    load_event = 1'b0;
    tick();
    tick();
    pop("pop_post_rst");
    chk_flags("final", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
